// File: rtl/if_id_queue.sv
// ---------------------------------------------------------------------------
// if_id_queue
//   Registered instruction queue between instruction fetch (IF) and decode
//   (ID). Captures {pc, instr} pairs from IF and presents the oldest one to
//   ID with a valid flag. The PC write-enable for IF comes from queue
//   occupancy only, so an ID stall never reaches the fetch path
//   combinationally. With DEPTH=2 and no stalls it acts as a plain one-cycle
//   IF/ID register.
//
// Parameters
//   DEPTH       number of entries (power of two, >= 2)
//   AW          pointer width, log2(DEPTH)
//
// Ports
//   clk         clock, all state updates on the rising edge
//   reset       synchronous active-high reset, empties the queue
//   pcValue_IF  PC of the instruction fetched this cycle
//   Instr_IF    instruction fetched this cycle
//   flush       discard every buffered entry and this cycle's fetch
//   stall_ID    ID cannot accept the head entry this cycle
//   WE_IF       PC write-enable to IF, high while the queue is not full
//   valid_ID    head entry valid
//   pcValue_ID  PC of the head entry, 0 when not valid
//   Instr_ID    instruction of the head entry, 0 (nop) when not valid
//   count       current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module if_id_queue #(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   pcValue_IF,
  input  logic [31:0]   Instr_IF,
  input  logic          flush,
  input  logic          stall_ID,
  output logic          WE_IF,
  output logic          valid_ID,
  output logic [31:0]   pcValue_ID,
  output logic [31:0]   Instr_ID,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  logic [63:0]   entries [DEPTH];
  logic [AW-1:0] rdPtr;
  logic [AW-1:0] wrPtr;
  logic          enq;
  logic          deq;
  logic [63:0]   headEntry;

  // Full blocks the PC update; reset also blocks it so nothing is written
  // into a queue that is being cleared.
  assign WE_IF    = (count != FullCount) && !reset;
  assign valid_ID = (count != '0);

  // A fetch presented in a flush cycle is wrong-path and is never stored.
  assign enq = WE_IF && !flush;
  assign deq = valid_ID && !stall_ID && !flush;

  assign headEntry = entries[rdPtr];

  // NOTE: every output of a combinational block is given a value on every
  // path (default first), otherwise synthesis infers a latch.
  always_comb begin
    pcValue_ID = '0;
    Instr_ID   = '0;
    if (valid_ID) begin
      pcValue_ID = headEntry[63:32];
      Instr_ID   = headEntry[31:0];
    end
  end

  // Pointers wrap naturally at AW bits; count carries the extra bit that
  // tells full from empty when the pointers are equal.
  // NOTE: sequential state is assigned with non-blocking (<=) so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (enq) wrPtr <= wrPtr + 1'b1;
      if (deq) rdPtr <= rdPtr + 1'b1;
      count <= count + (AW + 1)'(enq) - (AW + 1)'(deq);
    end
  end

  // NOTE: the storage array is deliberately not reset; stale contents are
  // never visible because the outputs are masked by valid_ID.
  always_ff @(posedge clk) begin
    if (enq) entries[wrPtr] <= {pcValue_IF, Instr_IF};
  end

endmodule
